// File: rtl/axi_r_beat_gen.sv
// axi_r_beat_gen
// Pairs {id, len} entries from the read-metadata FIFO with the in-order memory
// read-data stream and emits AXI R beats carrying the right rid and rlast.
// The output stage is a single register that sustains one beat per cycle.
// Optional feature: define AXI_R_BEAT_GEN_SLVERR_EN to add mem_err_i, which
// marks individual beats with an SLVERR response.
module axi_r_beat_gen #(
    parameter int AxiIdWidth = 4,
    parameter int DataWidth  = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    meta_valid_i,
    input  logic [AxiIdWidth+7:0]   meta_i,
    output logic                    meta_pop_o,
    input  logic                    mem_valid_i,
    input  logic [DataWidth-1:0]    mem_data_i,
`ifdef AXI_R_BEAT_GEN_SLVERR_EN
    input  logic                    mem_err_i,
`endif
    output logic                    mem_ready_o,
    output logic                    r_valid_o,
    input  logic                    r_ready_i,
    output logic [AxiIdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0]    r_data_o,
    output logic [1:0]              r_resp_o,
    output logic                    r_last_o,
    output logic                    busy_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [AxiIdWidth-1:0]  id_q;
    logic [7:0]             len_q;
    logic [7:0]             beat_cnt;
    logic                   out_free;
    logic                   meta_take;
    logic                   mem_hs;
    logic                   is_last;
    logic [1:0]             beat_resp;

    // The output register can take a new beat when empty or being drained now.
    assign out_free  = ~r_valid_o | r_ready_i;
    assign meta_take = (state == IDLE) & meta_valid_i;
    assign mem_hs    = (state == BURST) & mem_valid_i & out_free;
    assign is_last   = (beat_cnt == len_q);
    assign busy_o    = (state == BURST) | r_valid_o;

`ifdef AXI_R_BEAT_GEN_SLVERR_EN
    assign beat_resp = mem_err_i ? 2'b10 : 2'b00;
`else
    assign beat_resp = 2'b00;
`endif

    // Next-state and handshake strobes; strobes are forced low during reset.
    always_comb begin
        state_next  = state;
        meta_pop_o  = 1'b0;
        mem_ready_o = 1'b0;
        case (state)
            IDLE: begin
                meta_pop_o = meta_valid_i & ~rst_i;
                if (meta_valid_i) begin
                    state_next = BURST;
                end
            end
            BURST: begin
                mem_ready_o = out_free & ~rst_i;
                if (mem_hs && is_last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Burst context: latch id/len on pop, count accepted beats within the burst.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            id_q     <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
        end else if (meta_take) begin
            id_q     <= meta_i[AxiIdWidth+7:8];
            len_q    <= meta_i[7:0];
            beat_cnt <= '0;
        end else if (mem_hs) begin
            beat_cnt <= is_last ? 8'd0 : beat_cnt + 8'd1;
        end
    end

    // R output register: load on a memory handshake, otherwise clear once taken.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid_o <= 1'b0;
            r_id_o    <= '0;
            r_data_o  <= '0;
            r_resp_o  <= 2'b00;
            r_last_o  <= 1'b0;
        end else if (mem_hs) begin
            r_valid_o <= 1'b1;
            r_id_o    <= id_q;
            r_data_o  <= mem_data_i;
            r_resp_o  <= beat_resp;
            r_last_o  <= is_last;
        end else if (r_ready_i) begin
            r_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_r_beat_gen.sv
// Testbench for axi_r_beat_gen: queue-backed metadata FIFO and memory source,
// with a scoreboard of expected R beats filled when each burst is queued.
// Define AXI_R_BEAT_GEN_SLVERR_EN to also exercise the per-beat SLVERR path.
module tb_axi_r_beat_gen;

    localparam int AxiIdWidth = 4;
    localparam int DataWidth  = 64;

    typedef struct packed {
        logic [AxiIdWidth-1:0] id;
        logic [DataWidth-1:0]  data;
        logic                  last;
        logic [1:0]            resp;
    } beat_t;

    logic                   clk_i = 1'b0;
    logic                   rst_i = 1'b1;
    logic                   meta_valid_i = 1'b0;
    logic [AxiIdWidth+7:0]  meta_i = '0;
    logic                   meta_pop_o;
    logic                   mem_valid_i = 1'b0;
    logic [DataWidth-1:0]   mem_data_i = '0;
    logic                   mem_err_i = 1'b0;
    logic                   mem_ready_o;
    logic                   r_valid_o;
    logic                   r_ready_i = 1'b0;
    logic [AxiIdWidth-1:0]  r_id_o;
    logic [DataWidth-1:0]   r_data_o;
    logic [1:0]             r_resp_o;
    logic                   r_last_o;
    logic                   busy_o;

    logic [AxiIdWidth+7:0]  meta_q[$];
    logic [DataWidth-1:0]   mem_q[$];
    logic                   err_q[$];
    beat_t                  exp_q[$];

    int errors = 0;
    int checks = 0;
    int pops   = 0;
    int cycle  = 0;

    axi_r_beat_gen #(
        .AxiIdWidth (AxiIdWidth),
        .DataWidth  (DataWidth)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .meta_valid_i (meta_valid_i),
        .meta_i       (meta_i),
        .meta_pop_o   (meta_pop_o),
        .mem_valid_i  (mem_valid_i),
        .mem_data_i   (mem_data_i),
`ifdef AXI_R_BEAT_GEN_SLVERR_EN
        .mem_err_i    (mem_err_i),
`endif
        .mem_ready_o  (mem_ready_o),
        .r_valid_o    (r_valid_o),
        .r_ready_i    (r_ready_i),
        .r_id_o       (r_id_o),
        .r_data_o     (r_data_o),
        .r_resp_o     (r_resp_o),
        .r_last_o     (r_last_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Present the heads of the FIFO and memory queues to the DUT.
    task automatic drive_sources();
        meta_valid_i = (meta_q.size() != 0);
        meta_i       = '0;
        if (meta_q.size() != 0) meta_i = meta_q[0];
        mem_valid_i  = (mem_q.size() != 0);
        mem_data_i   = '0;
        mem_err_i    = 1'b0;
        if (mem_q.size() != 0) begin
            mem_data_i = mem_q[0];
            mem_err_i  = err_q[0];
        end
        #1;
    endtask

    // Advance one clock, retiring whatever handshakes were pending before the edge.
    task automatic step();
        logic meta_hs;
        logic mem_hs;
        meta_hs = meta_pop_o;
        mem_hs  = mem_valid_i & mem_ready_o;
        @(posedge clk_i);
        #1;
        cycle++;
        if (meta_hs) begin
            pops++;
            if (meta_q.size() != 0) void'(meta_q.pop_front());
        end
        if (mem_hs && mem_q.size() != 0) begin
            void'(mem_q.pop_front());
            void'(err_q.pop_front());
        end
        drive_sources();
    endtask

    // Queue one burst: metadata entry, memory beats base+i, and expected R beats.
    task automatic push_burst(input logic [AxiIdWidth-1:0] id, input int len,
                              input logic [DataWidth-1:0] base, input int err_beat);
        beat_t b;
        meta_q.push_back({id, 8'(len)});
        for (int i = 0; i <= len; i++) begin
            mem_q.push_back(base + DataWidth'(i));
            err_q.push_back(i == err_beat);
            b.id   = id;
            b.data = base + DataWidth'(i);
            b.last = (i == len);
            b.resp = (i == err_beat) ? 2'b10 : 2'b00;
            exp_q.push_back(b);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_i);
        #1;
        meta_valid_i = 1'b1;
        mem_valid_i  = 1'b1;
        r_ready_i    = 1'b1;
        #1;
        checks++;
        if ({r_valid_o, r_last_o, r_resp_o} !== 4'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got valid=%b last=%b resp=%b, expected 0/0/00",
                     r_valid_o, r_last_o, r_resp_o);
        end
        checks++;
        if (r_id_o !== '0 || r_data_o !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: got id=%h data=%h, expected 0/0", r_id_o, r_data_o);
        end
        checks++;
        if ({meta_pop_o, mem_ready_o, busy_o} !== 3'b0) begin
            errors++;
            $display("[TB] FAIL reset_strobes: got pop=%b mem_ready=%b busy=%b, expected 0/0/0",
                     meta_pop_o, mem_ready_o, busy_o);
        end
        drive_sources();
        rst_i = 1'b0;
        step();
        checks++;
        if (r_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: got valid=%b busy=%b, expected 0/0", r_valid_o, busy_o);
        end
    endtask

    task automatic test_single_beat();
        beat_t exp;
        pops = 0;
        r_ready_i = 1'b1;
        push_burst(4'h3, 0, 64'hA5, -1);
        drive_sources();
        checks++;
        if (meta_pop_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_pop: got %b, expected 1", meta_pop_o);
        end
        checks++;
        if (mem_ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_mem_ready: got %b, expected 0", mem_ready_o);
        end
        step();
        checks++;
        if (meta_pop_o !== 1'b0 || r_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_cycle1: got pop=%b valid=%b, expected 0/0", meta_pop_o, r_valid_o);
        end
        step();
        checks++;
        if (r_valid_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_latency: got valid=%b at cycle 2, expected 1", r_valid_o);
        end
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
            if (r_valid_o && r_ready_i) begin
                exp = exp_q.pop_front();
                checks++;
                if ({r_id_o, r_data_o, r_last_o, r_resp_o} !== exp) begin
                    errors++;
                    $display("[TB] FAIL single_beat: got id=%h data=%h last=%b resp=%b, expected id=%h data=%h last=%b resp=%b",
                             r_id_o, r_data_o, r_last_o, r_resp_o, exp.id, exp.data, exp.last, exp.resp);
                end
            end
            step();
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("[TB] FAIL single_timeout: got %0d beats left, expected 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (busy_o !== 1'b0 || pops != 1) begin
            errors++;
            $display("[TB] FAIL single_after: got busy=%b pops=%0d, expected 0/1", busy_o, pops);
        end
    endtask

    task automatic test_burst_throughput();
        beat_t exp;
        int first_c = 0;
        int last_c  = 0;
        int n = 0;
        r_ready_i = 1'b1;
        push_burst(4'h7, 3, 64'h0, -1);
        drive_sources();
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            if (r_valid_o && r_ready_i) begin
                if (n == 0) first_c = cycle;
                last_c = cycle;
                n++;
                exp = exp_q.pop_front();
                checks++;
                if ({r_id_o, r_data_o, r_last_o, r_resp_o} !== exp) begin
                    errors++;
                    $display("[TB] FAIL burst_beat: got id=%h data=%h last=%b resp=%b, expected id=%h data=%h last=%b resp=%b",
                             r_id_o, r_data_o, r_last_o, r_resp_o, exp.id, exp.data, exp.last, exp.resp);
                end
            end
            step();
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("[TB] FAIL burst_timeout: got %0d beats left, expected 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (last_c - first_c != 3) begin
            errors++;
            $display("[TB] FAIL burst_bubbles: got span=%0d cycles, expected 3", last_c - first_c);
        end
    endtask

    task automatic test_backpressure();
        beat_t exp;
        beat_t snap;
        r_ready_i = 1'b1;
        push_burst(4'h5, 1, 64'h11, -1);
        drive_sources();
        for (int c = 0; c < 10 && r_valid_o !== 1'b1; c++) step();
        r_ready_i = 1'b0;
        drive_sources();
        snap = {r_id_o, r_data_o, r_last_o, r_resp_o};
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (r_valid_o !== 1'b1 || {r_id_o, r_data_o, r_last_o, r_resp_o} !== snap
                || mem_ready_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold: got valid=%b id=%h data=%h last=%b mem_ready=%b, expected 1/%h/%h/%b/0",
                         r_valid_o, r_id_o, r_data_o, r_last_o, mem_ready_o, snap.id, snap.data, snap.last);
            end
        end
        r_ready_i = 1'b1;
        drive_sources();
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
            if (r_valid_o && r_ready_i) begin
                exp = exp_q.pop_front();
                checks++;
                if ({r_id_o, r_data_o, r_last_o, r_resp_o} !== exp) begin
                    errors++;
                    $display("[TB] FAIL stall_beat: got id=%h data=%h last=%b resp=%b, expected id=%h data=%h last=%b resp=%b",
                             r_id_o, r_data_o, r_last_o, r_resp_o, exp.id, exp.data, exp.last, exp.resp);
                end
            end
            step();
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("[TB] FAIL stall_timeout: got %0d beats left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        beat_t exp;
        int hs_c[3];
        int n = 0;
        pops = 0;
        r_ready_i = 1'b1;
        push_burst(4'h1, 1, 64'h100, -1);
        push_burst(4'h2, 0, 64'h200, -1);
        drive_sources();
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            if (r_valid_o && r_ready_i) begin
                if (n < 3) hs_c[n] = cycle;
                n++;
                exp = exp_q.pop_front();
                checks++;
                if ({r_id_o, r_data_o, r_last_o, r_resp_o} !== exp) begin
                    errors++;
                    $display("[TB] FAIL b2b_beat: got id=%h data=%h last=%b resp=%b, expected id=%h data=%h last=%b resp=%b",
                             r_id_o, r_data_o, r_last_o, r_resp_o, exp.id, exp.data, exp.last, exp.resp);
                end
            end
            step();
        end
        if (exp_q.size() != 0 || n != 3) begin
            checks++; errors++;
            $display("[TB] FAIL b2b_timeout: got %0d beats, expected 3", n);
            exp_q.delete();
        end else begin
            checks++;
            if (hs_c[1] - hs_c[0] != 1 || hs_c[2] - hs_c[1] != 2) begin
                errors++;
                $display("[TB] FAIL b2b_gap: got gaps %0d/%0d, expected 1/2",
                         hs_c[1] - hs_c[0], hs_c[2] - hs_c[1]);
            end
        end
        checks++;
        if (pops != 2) begin
            errors++;
            $display("[TB] FAIL b2b_pops: got %0d, expected 2", pops);
        end
    endtask

    task automatic test_max_len();
        beat_t exp;
        int n = 0;
        r_ready_i = 1'b1;
        push_burst(4'h9, 255, 64'hCAFE_0000, -1);
        drive_sources();
        for (int c = 0; c < 400 && exp_q.size() != 0; c++) begin
            if (r_valid_o && r_ready_i) begin
                n++;
                exp = exp_q.pop_front();
                checks++;
                if ({r_id_o, r_data_o, r_last_o, r_resp_o} !== exp) begin
                    errors++;
                    $display("[TB] FAIL maxlen_beat%0d: got id=%h data=%h last=%b, expected id=%h data=%h last=%b",
                             n, r_id_o, r_data_o, r_last_o, exp.id, exp.data, exp.last);
                end
            end
            step();
        end
        checks++;
        if (exp_q.size() != 0 || n != 256 || busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL maxlen_count: got %0d beats busy=%b, expected 256/0", n, busy_o);
            exp_q.delete();
        end
    endtask

    task automatic test_reset_midburst();
        beat_t exp;
        int n = 0;
        r_ready_i = 1'b1;
        push_burst(4'hA, 255, 64'h5000, -1);
        drive_sources();
        for (int c = 0; c < 40 && n < 10; c++) begin
            if (r_valid_o && r_ready_i) begin
                n++;
                exp = exp_q.pop_front();
                checks++;
                if ({r_id_o, r_data_o, r_last_o, r_resp_o} !== exp) begin
                    errors++;
                    $display("[TB] FAIL midrst_beat: got id=%h data=%h last=%b, expected id=%h data=%h last=%b",
                             r_id_o, r_data_o, r_last_o, exp.id, exp.data, exp.last);
                end
            end
            step();
        end
        if (n != 10) begin
            checks++; errors++;
            $display("[TB] FAIL midrst_timeout: got %0d beats, expected 10", n);
        end
        #2;
        rst_i = 1'b1;
        #1;
        checks++;
        if ({r_valid_o, r_last_o, r_resp_o, meta_pop_o, mem_ready_o, busy_o} !== 7'b0
            || r_id_o !== '0 || r_data_o !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset: got valid=%b id=%h data=%h last=%b resp=%b ready=%b busy=%b, expected all 0",
                     r_valid_o, r_id_o, r_data_o, r_last_o, r_resp_o, mem_ready_o, busy_o);
        end
        meta_q.delete();
        mem_q.delete();
        err_q.delete();
        exp_q.delete();
        @(posedge clk_i);
        #1;
        drive_sources();
        step();
        rst_i = 1'b0;
        repeat (3) step();
        checks++;
        if (r_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_no_partial: got valid=%b busy=%b, expected 0/0", r_valid_o, busy_o);
        end
        push_burst(4'hC, 2, 64'h7700, -1);
        drive_sources();
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            if (r_valid_o && r_ready_i) begin
                exp = exp_q.pop_front();
                checks++;
                if ({r_id_o, r_data_o, r_last_o, r_resp_o} !== exp) begin
                    errors++;
                    $display("[TB] FAIL post_reset_beat: got id=%h data=%h last=%b, expected id=%h data=%h last=%b",
                             r_id_o, r_data_o, r_last_o, exp.id, exp.data, exp.last);
                end
            end
            step();
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("[TB] FAIL post_reset_timeout: got %0d beats left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

`ifdef AXI_R_BEAT_GEN_SLVERR_EN
    task automatic test_slverr();
        beat_t exp;
        r_ready_i = 1'b1;
        push_burst(4'h2, 2, 64'h300, 1);
        drive_sources();
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            if (r_valid_o && r_ready_i) begin
                exp = exp_q.pop_front();
                checks++;
                if ({r_id_o, r_data_o, r_last_o, r_resp_o} !== exp) begin
                    errors++;
                    $display("[TB] FAIL slverr_beat: got id=%h data=%h last=%b resp=%b, expected id=%h data=%h last=%b resp=%b",
                             r_id_o, r_data_o, r_last_o, r_resp_o, exp.id, exp.data, exp.last, exp.resp);
                end
            end
            step();
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("[TB] FAIL slverr_timeout: got %0d beats left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_beat();
        test_burst_throughput();
        test_backpressure();
        test_back_to_back();
        test_max_len();
        test_reset_midburst();
`ifdef AXI_R_BEAT_GEN_SLVERR_EN
        test_slverr();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_r_beat_gen.md
Name: axi_r_beat_gen

Overview:
Downstream consumer of the read-metadata FIFO in the axi_to_mem path. Pops one {id, len} entry per read burst and pairs it with the in-order memory read-data stream. Emits AXI R-channel beats with the correct rid and rlast. Registered output stage with full throughput inside a burst.

Parameters:
AxiIdWidth, 4, width of the AXI ID field carried in the metadata entry and driven on r_id_o.
DataWidth, 64, width of memory read data and r_data_o.

Ports:
clk_i  input  1  clock; all logic rising-edge.
rst_i  input  1  reset, asynchronous, active-high.
meta_valid_i  input  1  metadata FIFO non-empty (inverse of FIFO empty_o).
meta_i  input  AxiIdWidth+8  FIFO data_o; [AxiIdWidth+7:8]=id, [7:0]=len (beats-1).
meta_pop_o  output  1  pop strobe to FIFO pop_i.
mem_valid_i  input  1  memory read data valid.
mem_data_i  input  DataWidth  memory read data.
mem_ready_o  output  1  read data accepted when mem_valid_i & mem_ready_o.
r_valid_o  output  1  AXI rvalid.
r_ready_i  input  1  AXI rready.
r_id_o  output  AxiIdWidth  AXI rid.
r_data_o  output  DataWidth  AXI rdata.
r_resp_o  output  2  AXI rresp.
r_last_o  output  1  AXI rlast.
busy_o  output  1  high while FSM in BURST or r_valid_o high.

Behaviour:
- Reset (rst_i high, any time, async): FSM=IDLE, beat_cnt=0, id/len regs=0, r_valid_o=0, r_id_o=0, r_data_o=0, r_resp_o=2'b00, r_last_o=0. meta_pop_o and mem_ready_o are 0 while rst_i is high. A burst in flight is dropped; no partial beats after release.
- out_free = ~r_valid_o | r_ready_i.
- FSM IDLE:
  - meta_pop_o = meta_valid_i; mem_ready_o = 0.
  - On meta_valid_i: latch id=meta_i[AxiIdWidth+7:8], len=meta_i[7:0]; beat_cnt<=0; go BURST.
  - One pop per cycle maximum. meta_pop_o is never asserted while meta_valid_i=0.
- FSM BURST:
  - meta_pop_o = 0; mem_ready_o = out_free.
  - On a mem handshake, the output register loads: r_data_o=mem_data_i, r_id_o=id, r_resp_o=2'b00 (OKAY), r_last_o=(beat_cnt==len), r_valid_o=1. Then beat_cnt<=beat_cnt+1.
  - If that beat is last: beat_cnt<=0 and go IDLE.
- Output register:
  - If r_valid_o & r_ready_i with no new load, r_valid_o<=0.
  - While r_valid_o & ~r_ready_i, all r_* outputs hold stable (AXI rule) and mem_ready_o=0.
- Latency:
  - Meta accepted at cycle N; first mem beat accepted earliest at N+1; r_valid_o rises at N+2.
  - Inside a burst with r_ready_i=1 and mem_valid_i=1: one beat per cycle, no bubbles.
  - One idle cycle (IDLE state) between consecutive bursts.
- Arithmetic: beat_cnt is 8 bits. Compare is exact equality with len, so len=255 yields exactly 256 beats with no overflow. len=0 yields a single beat with r_last_o=1.
- Simultaneous events: output handshake and new load in the same cycle keeps r_valid_o=1 and takes the new values. A mem beat arriving in IDLE is not accepted.
- busy_o = (state==BURST) | r_valid_o.

Optional Feature:
Macro AXI_R_BEAT_GEN_SLVERR_EN.
- Defined:
  - Extra input port mem_err_i (1 bit), qualified with mem_valid_i.
  - A beat loaded with mem_err_i=1 drives r_resp_o=2'b10 (SLVERR); otherwise 2'b00.
  - The error is per beat and does not terminate the burst early.
- Not defined: no mem_err_i port; r_resp_o is constant 2'b00 after reset.

Test Plan:
- Single beat: meta id=4'h3 len=0, mem_data=64'hA5, r_ready_i=1 -> meta_pop_o for 1 cycle; one R beat with id=3, data=A5, last=1, resp=0; r_valid_o at cycle 2; busy_o low afterwards.
- Burst throughput: meta id=4'h7 len=3, mem_valid_i=1 each cycle with data 0..3, r_ready_i=1 -> 4 consecutive beats data 0,1,2,3; last only on data=3; id=7 throughout.
- Backpressure: len=1, r_ready_i low for 5 cycles after the first beat -> r_data/r_id/r_last stable; mem_ready_o=0 for those cycles; second beat follows with last=1.
- Back-to-back bursts: FIFO holds {id1,len1},{id2,len0} -> 2 beats with id1 then 1 beat with id2; exactly one idle cycle between them; exactly two pops total.
- Max length and reset: len=255 -> 256 beats, r_last_o only on the 256th. Repeat and assert rst_i after beat 10 -> all outputs zero immediately (asynchronously). After release, a fresh meta entry produces a correct burst.
- With AXI_R_BEAT_GEN_SLVERR_EN: len=2, mem_err_i=1 on beat 1 only -> r_resp_o sequence 0,2,0; last on beat 2.
